// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues hold-until-response word reads and buffers
// one returned instruction with its PC for the instruction register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  typedef enum logic [1:0] {
    StWait    = 2'd0,
    StFetch   = 2'd1,
    StDiscard = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q, out_pc_d;

  logic [31:0] target;
  logic        consume;

  assign target  = redirect_pc & ~32'h3;
  assign consume = out_valid_q & ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StWait;
      pc_q        <= RESET_PC;
      tgt_q       <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      tgt_q       <= tgt_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    tgt_d       = tgt_q;
    out_valid_d = out_valid_q & ~consume;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;

    unique case (state_q)
      StWait: begin
        if (redirect) begin
          pc_d    = target;
          state_d = StFetch;
        end else if (!out_valid_q || consume) begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (redirect) begin
          if (imem_resp) begin
            pc_d = target;
          end else begin
            tgt_d   = target;
            state_d = StDiscard;
          end
        end else if (imem_resp) begin
          // Buffer is known empty here: FETCH is only entered once it has drained.
          out_instr_d = imem_rdata;
          out_pc_d    = pc_q;
          out_valid_d = 1'b1;
          pc_d        = pc_q + 32'd4;
          state_d     = StWait;
        end
      end
      StDiscard: begin
        if (redirect) begin
          tgt_d = target;
          if (imem_resp) begin
            pc_d    = target;
            state_d = StFetch;
          end
        end else if (imem_resp) begin
          pc_d    = tgt_q;
          state_d = StFetch;
        end
      end
      default: state_d = StWait;
    endcase

    // Redirect flushes the buffer regardless of consume or capture.
    if (redirect) begin
      out_valid_d = 1'b0;
    end
  end

  assign imem_read    = (state_q == StFetch) || (state_q == StDiscard);
  assign imem_address = pc_q;
  assign out_valid    = out_valid_q;
  assign out_instr    = out_instr_q;
  assign out_pc       = out_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: latency-programmable memory model plus a scoreboard of
// expected {pc, instr} pairs popped whenever downstream consumes the output buffer.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int          errors = 0;
  int          checks = 0;
  int          lat = 0;
  int          cnt = 0;
  bit          nop_mode = 1'b1;
  logic [63:0] sb_q[$];

  fetch_unit #(.RESET_PC(32'h0000_0060)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .stall        (stall),
    .out_valid    (out_valid),
    .out_instr    (out_instr),
    .out_pc       (out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return nop_mode ? 32'h0000_0013 : (a ^ 32'hC0DE_0013);
  endfunction

  // Memory answers once the request has been held for `lat` cycles (0 = same cycle).
  assign imem_resp  = imem_read && (cnt >= lat);
  assign imem_rdata = imem_resp ? mem_data(imem_address) : 32'hDEAD_BEEF;

  always_ff @(posedge clk) begin
    if (!imem_read || imem_resp) cnt <= 0;
    else cnt <= cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] a);
    sb_q.push_back({a, mem_data(a)});
  endtask

  // Pops the scoreboard on a consume, then advances to the next cycle's midpoint.
  task automatic cyc();
    logic [63:0] e;
    if (out_valid && !stall) begin
      chk("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("sb_out_pc", out_pc, e[63:32]);
        chk("sb_out_instr", out_instr, e[31:0]);
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 40 && !out_valid; i++) cyc();
    chk(tag, 32'(out_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    stall       = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_imem_read", 32'(imem_read), 32'd0);
    chk("rst_imem_address", imem_address, 32'h60);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);

    // Cycle 0 after release, then reads every other cycle with a same-cycle memory.
    rst_n = 1'b1;
    push_exp(32'h60);
    push_exp(32'h64);
    push_exp(32'h68);
    chk("c0_read", 32'(imem_read), 32'd0);
    cyc();
    for (int k = 0; k < 3; k++) begin
      chk("read_hi", 32'(imem_read), 32'd1);
      chk("read_addr", imem_address, 32'h60 + 32'(4 * k));
      chk("read_no_valid", 32'(out_valid), 32'd0);
      cyc();
      chk("valid_hi", 32'(out_valid), 32'd1);
      chk("valid_no_read", 32'(imem_read), 32'd0);
      if (k < 2) cyc();
    end

    // Hold stall for five cycles with 0x68 buffered.
    nop_mode = 1'b0;
    stall    = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("stall_read", 32'(imem_read), 32'd0);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_pc", out_pc, 32'h68);
      chk("stall_instr", out_instr, 32'h13);
      cyc();
    end
    stall = 1'b0;
    lat   = 3;
    chk("unstall_read", 32'(imem_read), 32'd0);
    cyc();
    chk("resume_read", 32'(imem_read), 32'd1);
    chk("resume_addr", imem_address, 32'h6C);
    cyc();

    // Redirect while the 3-cycle read of 0x6C is outstanding.
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0203;
    cyc();
    redirect = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("disc_read", 32'(imem_read), 32'd1);
      chk("disc_addr", imem_address, 32'h6C);
      chk("disc_valid", 32'(out_valid), 32'd0);
      cyc();
    end
    chk("redir_addr", imem_address, 32'h200);
    chk("redir_valid", 32'(out_valid), 32'd0);
    push_exp(32'h200);
    wait_valid("wait_200");
    chk("valid_pc_200", out_pc, 32'h200);
    lat = 0;
    cyc();

    // Redirect coincident with a response in FETCH: the response is dropped.
    chk("coin_addr", imem_address, 32'h204);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0400;
    cyc();
    redirect = 1'b0;
    lat      = 6;
    chk("coin_next_read", 32'(imem_read), 32'd1);
    chk("coin_next_addr", imem_address, 32'h400);
    chk("coin_valid", 32'(out_valid), 32'd0);

    // Two redirects inside one DISCARD window; only the newest target is fetched.
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    cyc();
    redirect_pc = 32'h0000_0300;
    chk("disc2_addr", imem_address, 32'h400);
    cyc();
    redirect = 1'b0;
    for (int k = 0; k < 20 && imem_address == 32'h400; k++) cyc();
    chk("disc2_read", 32'(imem_read), 32'd1);
    chk("disc2_target", imem_address, 32'h300);
    push_exp(32'h300);
    wait_valid("wait_300");

    // Redirect from WAIT to the top word, then let pc+4 wrap to zero.
    lat         = 0;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    cyc();
    redirect = 1'b0;
    chk("top_addr", imem_address, 32'hFFFF_FFFC);
    chk("top_valid", 32'(out_valid), 32'd0);
    push_exp(32'hFFFF_FFFC);
    cyc();
    chk("top_out_pc", out_pc, 32'hFFFF_FFFC);
    lat = 10;
    cyc();
    chk("wrap_read", 32'(imem_read), 32'd1);
    chk("wrap_addr", imem_address, 32'h0);

    // Asynchronous reset with the read to 0 still outstanding.
    rst_n = 1'b0;
    #1;
    chk("arst_read", 32'(imem_read), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_addr", imem_address, 32'h60);
    @(negedge clk);
    rst_n = 1'b1;
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
